user_pulse_decoder: RTL and testbench

Receive-side counterpart of the user-domain pulse generator. Samples an external pulse train, measures the high time and period of each pulse in clk_i cycles, counts completed periods and reports each measurement with a one-cycle valid strobe. Sits in the user domain next to the generator; software or loopback logic arms it, and it stops on pulse count, timeout or abort.

---
 rtl/user_pulse_decoder.sv | 195 +++++++++++++++++++
 tb/tb_user_pulse_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_pulse_decoder.sv
// user_pulse_decoder: receive-side pulse measurement block.
// Samples an asynchronous pulse line, measures the high time and the
// rise-to-rise period of each pulse in clk_i cycles, counts completed periods
// and strobes valid_o for one cycle per measurement. Capture is armed with
// start_i. It ends on the pulse count, on a per-period timeout, or on stop_i.
//
// Optional feature: define USER_PULSE_DECODER_GLITCH_FILTER_EN to insert a
// 3-cycle stability filter between the invert stage and the edge detector.
module user_pulse_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pulse_i,
  input  logic                 invert_in_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [7:0]           max_pulses_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 valid_o,
  output logic [7:0]           pulse_cnt_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_raw;
  logic                   lvl;
  logic                   lvl_prev_q;
  logic                   rise;
  logic                   fall;
  logic [CNT_WIDTH-1:0]   cyc_cnt_q;
  logic [CNT_WIDTH-1:0]   high_q;
  logic [CNT_WIDTH-1:0]   high_out_q;
  logic [CNT_WIDTH-1:0]   period_q;
  logic                   valid_q;
  logic [7:0]             pulse_cnt_q;
  logic [7:0]             pulse_cnt_next;
  logic                   timeout_q;
  logic                   timeout_hit;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Synchroniser chain on the asynchronous pulse line, running in every state.
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
    end
  end

  assign lvl_raw = sync_q[SYNC_STAGES-1] ^ invert_in_i;

`ifdef USER_PULSE_DECODER_GLITCH_FILTER_EN
  logic       filt_q;
  logic [1:0] stab_cnt_q;

  // The filtered level follows lvl_raw on the third consecutive cycle that
  // lvl_raw differs from it. That is two cycles later than the raw change.
  assign lvl = ((lvl_raw != filt_q) && (stab_cnt_q == 2'd2)) ? lvl_raw : filt_q;

  // Stability counter: counts consecutive cycles of disagreement, capped at 2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q     <= 1'b0;
      stab_cnt_q <= 2'd0;
    end else begin
      filt_q <= lvl;
      if (lvl_raw == lvl) begin
        stab_cnt_q <= 2'd0;
      end else if (stab_cnt_q != 2'd2) begin
        stab_cnt_q <= stab_cnt_q + 2'd1;
      end
    end
  end
`else
  assign lvl = lvl_raw;
`endif

  // Edge-detect flop holding the previous cycle's level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_prev_q <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
    end
  end

  assign rise           = lvl & ~lvl_prev_q;
  assign fall           = ~lvl & lvl_prev_q;
  assign pulse_cnt_next = pulse_cnt_q + 8'd1;
  assign timeout_hit    = (timeout_i != '0) && (cyc_cnt_q == timeout_i);

  // Capture FSM. Priority: stop, then the edge that ends the phase, then the
  // timeout, then start. An edge in the same cycle as the timeout wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cyc_cnt_q   <= '0;
      high_q      <= '0;
      high_out_q  <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      pulse_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (stop_i) begin
        state_q   <= S_IDLE;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              state_q     <= S_ARMED;
              cyc_cnt_q   <= '0;
              pulse_cnt_q <= 8'd0;
              timeout_q   <= 1'b0;
              high_out_q  <= '0;
              period_q    <= '0;
            end
          end
          S_ARMED: begin
            if (rise) begin
              cyc_cnt_q <= CNT_ONE;
              state_q   <= S_HIGH;
            end
          end
          S_HIGH: begin
            if (fall) begin
              high_q    <= cyc_cnt_q;
              cyc_cnt_q <= sat_inc(cyc_cnt_q);
              state_q   <= S_LOW;
            end else if (timeout_hit) begin
              timeout_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              cyc_cnt_q <= sat_inc(cyc_cnt_q);
            end
          end
          S_LOW: begin
            if (rise) begin
              period_q    <= cyc_cnt_q;
              high_out_q  <= high_q;
              valid_q     <= 1'b1;
              pulse_cnt_q <= pulse_cnt_next;
              cyc_cnt_q   <= CNT_ONE;
              if ((max_pulses_i != 8'd0) && (pulse_cnt_next == max_pulses_i)) begin
                state_q <= S_DONE;
              end else begin
                state_q <= S_HIGH;
              end
            end else if (timeout_hit) begin
              timeout_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              cyc_cnt_q <= sat_inc(cyc_cnt_q);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign high_o      = high_out_q;
  assign period_o    = period_q;
  assign valid_o     = valid_q;
  assign pulse_cnt_o = pulse_cnt_q;
  assign done_o      = (state_q == S_DONE);
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_user_pulse_decoder.sv
// Testbench for user_pulse_decoder: table-driven waveform scenarios plus
// hand-written corner sequences. Measurements are checked through a
// scoreboard queue that is filled when stimulus is driven.
module tb_user_pulse_decoder;

  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          pulse_i;
  logic          invert_in_i;
  logic          start_i;
  logic          stop_i;
  logic [7:0]    max_pulses_i;
  logic [CW-1:0] timeout_i;
  logic [CW-1:0] high_o;
  logic [CW-1:0] period_o;
  logic          valid_o;
  logic [7:0]    pulse_cnt_o;
  logic          done_o;
  logic          timeout_o;
  logic [2:0]    state_o;

  user_pulse_decoder #(.SYNC_STAGES(2), .CNT_WIDTH(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pulse_i      (pulse_i),
    .invert_in_i  (invert_in_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .max_pulses_i (max_pulses_i),
    .timeout_i    (timeout_i),
    .high_o       (high_o),
    .period_o     (period_o),
    .valid_o      (valid_o),
    .pulse_cnt_o  (pulse_cnt_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int high;
    int period;
    int cnt;
  } exp_t;

  typedef struct {
    logic       inv;
    logic [7:0] max;
    int         h;
    int         l;
    int         nper;
    int         exp_cnt;
    int         exp_high;
    int         exp_period;
    logic       exp_done;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic arm();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic drive_period(input int h, input int l);
    pulse_i = 1'b1;
    repeat (h) tick();
    pulse_i = 1'b0;
    repeat (l) tick();
  endtask

  task automatic glitch_period();
    logic [9:0] bits;
    bits = 10'b1110100010;
    for (int i = 9; i >= 0; i--) begin
      pulse_i = bits[i];
      tick();
    end
  endtask

  task automatic push_exp(input int h, input int p, input int c);
    exp_t e;
    e.high = h;
    e.period = p;
    e.cnt = c;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every valid_o strobe must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'd0, valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_high", 32'(high_o), e.high);
        check("sb_period", 32'(period_o), e.period);
        check("sb_pulse_cnt", 32'(pulse_cnt_o), e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    rst_i = 1'b1;
    pulse_i = 1'b0;
    invert_in_i = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    max_pulses_i = 8'd0;
    timeout_i = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Reset state.
    check("rst_state", 32'(state_o), 0);
    check("rst_high", 32'(high_o), 0);
    check("rst_period", 32'(period_o), 0);
    check("rst_cnt", 32'(pulse_cnt_o), 0);
    check("rst_flags", {29'd0, valid_o, done_o, timeout_o}, 0);

    // Waveform table.
    vecs.push_back('{1'b0, 8'd3, 4, 6, 4, 3, 4, 10, 1'b1});
    vecs.push_back('{1'b1, 8'd1, 4, 6, 4, 1, 6, 10, 1'b1});
    vecs.push_back('{1'b1, 8'd2, 3, 5, 4, 2, 5, 8, 1'b1});
`ifndef USER_PULSE_DECODER_GLITCH_FILTER_EN
    vecs.push_back('{1'b0, 8'd0, 2, 3, 4, 3, 2, 5, 1'b0});
    vecs.push_back('{1'b0, 8'd0, 1, 1, 5, 4, 1, 2, 1'b0});
`endif

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      pulse_i = 1'b0;
      invert_in_i = v.inv;
      max_pulses_i = v.max;
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      repeat (5) tick();
      arm();
      check($sformatf("v%0d_armed", r), 32'(state_o), 1);
      check($sformatf("v%0d_arm_clear", r), {period_o, 8'd0, pulse_cnt_o}, 0);
      for (int k = 1; k <= v.exp_cnt; k++) push_exp(v.exp_high, v.exp_period, k);
      for (int p = 0; p < v.nper; p++) drive_period(v.h, v.l);
      repeat (8) tick();
      check($sformatf("v%0d_sb_empty", r), 32'(sb.size()), 0);
      check($sformatf("v%0d_cnt", r), 32'(pulse_cnt_o), v.exp_cnt);
      check($sformatf("v%0d_done", r), {31'd0, done_o}, {31'd0, v.exp_done});
      check($sformatf("v%0d_state", r), 32'(state_o), v.exp_done ? 4 : 3);
      check($sformatf("v%0d_tmo", r), {31'd0, timeout_o}, 0);
      sb.delete();
    end

    // Timeout: line rises once and stays high.
    pulse_i = 1'b0;
    invert_in_i = 1'b0;
    max_pulses_i = 8'd0;
    timeout_i = CW'(20);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    repeat (4) tick();
    arm();
    pulse_i = 1'b1;
    n = 0;
    while (state_o != 3'd2 && n < 50) begin
      tick();
      n++;
    end
    check("tmo_enter_high", 32'(state_o), 2);
    n = 0;
    while (state_o != 3'd4 && n < 100) begin
      tick();
      n++;
    end
    check("tmo_latency", n, 20);
    check("tmo_flag", {31'd0, timeout_o}, 1);
    check("tmo_done", {31'd0, done_o}, 1);
    check("tmo_cnt", 32'(pulse_cnt_o), 0);
    arm();
    check("tmo_rearm_state", 32'(state_o), 1);
    check("tmo_rearm_clear", {31'd0, timeout_o}, 0);
    pulse_i = 1'b0;
    timeout_i = '0;

    // Stop mid-LOW after two periods, unlimited count.
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    repeat (4) tick();
    arm();
    push_exp(3, 6, 1);
    push_exp(3, 6, 2);
    for (int p = 0; p < 3; p++) drive_period(3, 3);
    repeat (3) tick();
    check("stop_pre_state", 32'(state_o), 3);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("stop_state", 32'(state_o), 0);
    check("stop_cnt_held", 32'(pulse_cnt_o), 2);
    check("stop_vals_held", {high_o, period_o}, {16'd3, 16'd6});
    for (int p = 0; p < 2; p++) drive_period(4, 4);
    repeat (4) tick();
    check("stop_idle_after", 32'(state_o), 0);
    check("stop_sb_empty", 32'(sb.size()), 0);

    // start and stop together in IDLE.
    start_i = 1'b1;
    stop_i = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i = 1'b0;
    check("start_stop_idle", 32'(state_o), 0);

    // Glitchy 5/5 train.
`ifdef USER_PULSE_DECODER_GLITCH_FILTER_EN
    max_pulses_i = 8'd2;
    arm();
    push_exp(5, 10, 1);
    push_exp(5, 10, 2);
    for (int p = 0; p < 3; p++) glitch_period();
    repeat (8) tick();
    check("glitch_cnt", 32'(pulse_cnt_o), 2);
`else
    max_pulses_i = 8'd3;
    arm();
    push_exp(3, 4, 1);
    push_exp(1, 4, 2);
    push_exp(1, 2, 3);
    for (int p = 0; p < 2; p++) glitch_period();
    repeat (8) tick();
    check("glitch_cnt", 32'(pulse_cnt_o), 3);
`endif
    check("glitch_done", {31'd0, done_o}, 1);
    check("glitch_sb_empty", 32'(sb.size()), 0);

    // Reset in the middle of HIGH.
    max_pulses_i = 8'd0;
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    arm();
    push_exp(4, 10, 1);
    drive_period(4, 6);
    pulse_i = 1'b1;
    repeat (6) tick();
    check("rst_mid_pre_state", 32'(state_o), 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_state", 32'(state_o), 0);
    check("rst_mid_vals", {high_o, period_o}, 0);
    check("rst_mid_flags", {21'd0, pulse_cnt_o, valid_o, done_o, timeout_o}, 0);
    pulse_i = 1'b0;
    repeat (4) tick();
    check("rst_mid_sb_empty", 32'(sb.size()), 0);
    check("rst_mid_idle", 32'(state_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
